nmea_header_matcher: RTL

Synchronous multi-pattern header matcher for byte streams. It is the parametrised successor of the single-header comparer in the GPZDA receive path. It tracks up to N fixed-length reference headers at once, for example "$GPZDA", "$GPRMC" and "$GPGGA". It resynchronises on the byte that broke a partial match, and it reports which header completed. It sits between the UART byte receiver and the sentence field parsers.

---
 rtl/nmea_header_matcher.sv | 113 +++++++++++
 1 files changed

// File: rtl/nmea_header_matcher.sv
// Tracks N fixed-length reference headers in parallel over a byte stream; one byte per clock.
// resolve/reject/progress appear one clock after the deciding byte; no backpressure, every load is consumed.
module nmea_header_matcher #(
  parameter int B = 8,
  parameter int L = 6,
  parameter int N = 4,
  parameter logic [N*L*B-1:0] REFS = {"$GPZDA", "$GPRMC", "$GPGGA", "$GNGGA"},
  parameter int IW = (N > 1) ? $clog2(N) : 1,
  localparam int PW = $clog2(L + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          restart,
  input  logic          load,
  input  logic [B-1:0]  data,
  input  logic [N-1:0]  enable,
  output logic          resolve,
  output logic [IW-1:0] resolve_id,
  output logic          reject,
  output logic [PW-1:0] progress
);

  localparam logic [PW-1:0] LAST = PW'(L - 1);

  logic [PW-1:0] pos, pos_nxt;
  logic [N-1:0]  alive, alive_nxt;
  logic [N-1:0]  hit, seed;
  logic          resolve_nxt, reject_nxt;
  logic [IW-1:0] id_nxt;

  function automatic logic [B-1:0] ref_byte(input int i, input int p);
    return REFS[((N-1-i)*L + L-1-p)*B +: B];
  endfunction

  // Lowest set index wins, so duplicate references resolve to the smaller id.
  function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  always_comb begin
    hit  = '0;
    seed = '0;
    for (int i = 0; i < N; i++) begin
      hit[i]  = alive[i] & enable[i] & (ref_byte(i, int'(pos)) == data);
      seed[i] = enable[i] & (ref_byte(i, 0) == data);
    end
  end

  always_comb begin
    pos_nxt     = pos;
    alive_nxt   = alive;
    resolve_nxt = 1'b0;
    reject_nxt  = 1'b0;
    id_nxt      = resolve_id;
    if (restart) begin
      pos_nxt   = '0;
      alive_nxt = '1;
    end else if (load) begin
      if (|hit) begin
        if (pos == LAST) begin
          resolve_nxt = 1'b1;
          id_nxt      = lowest(hit);
          pos_nxt     = '0;
          alive_nxt   = '1;
        end else begin
          alive_nxt = hit;
          pos_nxt   = pos + PW'(1);
        end
      end else begin
        // The breaking byte is re-examined as byte 0 of a fresh attempt.
        reject_nxt = (pos != '0);
        if (|seed) begin
          if (L == 1) begin
            resolve_nxt = 1'b1;
            id_nxt      = lowest(seed);
            pos_nxt     = '0;
            alive_nxt   = '1;
          end else begin
            alive_nxt = seed;
            pos_nxt   = PW'(1);
          end
        end else begin
          pos_nxt   = '0;
          alive_nxt = '1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos        <= '0;
      alive      <= '1;
      resolve    <= 1'b0;
      resolve_id <= '0;
      reject     <= 1'b0;
    end else begin
      pos        <= pos_nxt;
      alive      <= alive_nxt;
      resolve    <= resolve_nxt;
      resolve_id <= id_nxt;
      reject     <= reject_nxt;
    end
  end

  assign progress = pos;

endmodule
